lin_interp_pipe: RTL and testbench

- Pipelined, parametrised piecewise-linear interpolator for LUT-based activation functions (sigmoid/tanh gates in the LSTM datapath).
- Sits between the activation LUT readout (base, next_data, fractional index) and the gate multiplier.
- Generalises the 8-bit combinational interpolator with:
  - configurable data and fraction widths;
  - rounding mode;
  - saturation on extrapolation;
  - valid/ready streaming with backpressure.

---
 rtl/act_interp_pkg.sv | 30 +++
 rtl/pipe_stage_ctl.sv | 21 ++
 rtl/lin_interp_pipe.sv | 94 +++++++++
 tb/tb_lin_interp_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/act_interp_pkg.sv
// Shared helpers for the activation-LUT interpolators: signed clamping
// and the rounding bias that is added before the fraction shift.
package act_interp_pkg;

    localparam int unsigned CALC_W = 64;

    typedef struct packed {
        logic                     ovf;
        logic signed [CALC_W-1:0] val;
    } sat_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic sat_t sat_signed(input logic signed [CALC_W-1:0] value,
                                        input int unsigned width);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sat_t r;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (value > hi) || (value < lo);
        r.val = (value > hi) ? hi : ((value < lo) ? lo : value);
        return r;
    endfunction

    function automatic logic signed [CALC_W-1:0] round_bias(input int unsigned frac_w,
                                                             input bit round);
        return (round && frac_w > 0) ? (64'sd1 <<< (frac_w - 1)) : '0;
    endfunction

endpackage

// File: rtl/pipe_stage_ctl.sv
// Valid/load control for one elastic pipeline stage; the load term
// ripples backward so bubbles collapse within a single cycle.
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst,
    input  logic in_v,
    input  logic ld_next,
    output logic v,
    output logic ld
);

    assign ld = !v | ld_next;

    always_ff @(posedge clk) begin
        if (!rst)
            v <= 1'b0;
        else if (ld)
            v <= in_v;
    end

endmodule

// File: rtl/lin_interp_pipe.sv
// Three-stage piecewise-linear interpolator with rounding, saturation
// and valid/ready backpressure.
module lin_interp_pipe
    import act_interp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int REM_W  = 4,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next_data,
    input  logic        [REM_W-1:0]  remaining,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] interpolated_value,
    output logic                     out_sat
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + 1 + REM_W + 1;
    localparam int SUM_W  = PROD_W + 1;

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    pipe_stage_ctl u_ctl1 (.clk(clk), .rst(rst), .in_v(in_valid), .ld_next(ld2),       .v(v1), .ld(ld1));
    pipe_stage_ctl u_ctl2 (.clk(clk), .rst(rst), .in_v(v1),       .ld_next(ld3),       .v(v2), .ld(ld2));
    pipe_stage_ctl u_ctl3 (.clk(clk), .rst(rst), .in_v(v2),       .ld_next(out_ready), .v(v3), .ld(ld3));

    assign in_ready  = ld1;
    assign out_valid = v3;

    logic signed [DIFF_W-1:0] d1;
    logic signed [DATA_W-1:0] b1, b2;
    logic        [REM_W-1:0]  r1;
    logic signed [PROD_W-1:0] p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d1 <= '0;
            b1 <= '0;
            r1 <= '0;
        end else if (ld1) begin
            d1 <= DIFF_W'(next_data) - DIFF_W'(base);
            b1 <= base;
            r1 <= remaining;
        end
    end

    logic signed [PROD_W-1:0] rem_x;
    logic signed [PROD_W-1:0] prod;

    assign rem_x = $signed(PROD_W'(r1));
    assign prod  = PROD_W'(d1) * rem_x + PROD_W'(round_bias(FRAC_W, ROUND != 0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            p2 <= '0;
            b2 <= '0;
        end else if (ld2) begin
            p2 <= prod;
            b2 <= b1;
        end
    end

    logic signed [PROD_W-1:0] q;
    logic signed [SUM_W-1:0]  sum;
    sat_t                     clamp;
    logic signed [DATA_W-1:0] res;

    always_comb begin
        q     = p2 >>> FRAC_W;
        sum   = SUM_W'(b2) + SUM_W'(q);
        clamp = sat_signed(64'(sum), DATA_W);
        res   = (SAT != 0) ? clamp.val[DATA_W-1:0] : sum[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            interpolated_value <= '0;
            out_sat            <= 1'b0;
        end else if (ld3) begin
            interpolated_value <= res;
            out_sat            <= clamp.ovf;
        end
    end

endmodule

// File: tb/tb_lin_interp_pipe.sv
// Four configurations of lin_interp_pipe driven by one shared stream and
// checked against an arithmetic reference model and an in-flight queue.
module tb_lin_interp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic signed [7:0] base = '0;
    logic signed [7:0] next_data = '0;
    logic        [5:0] remaining = '0;

    logic              ir[4];
    logic              ov[4];
    logic              os[4];
    logic signed [7:0] iv[4];

    // 0: floor/sat, 1: round/sat, 2: extrapolating sat, 3: extrapolating wrap
    lin_interp_pipe #(.DATA_W(8), .FRAC_W(4), .REM_W(4), .ROUND(0), .SAT(1)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .base(base),
        .next_data(next_data), .remaining(remaining[3:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .interpolated_value(iv[0]), .out_sat(os[0]));
    lin_interp_pipe #(.DATA_W(8), .FRAC_W(4), .REM_W(4), .ROUND(1), .SAT(1)) u_rnd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .base(base),
        .next_data(next_data), .remaining(remaining[3:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .interpolated_value(iv[1]), .out_sat(os[1]));
    lin_interp_pipe #(.DATA_W(8), .FRAC_W(4), .REM_W(6), .ROUND(0), .SAT(1)) u_xsat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .base(base),
        .next_data(next_data), .remaining(remaining), .out_valid(ov[2]),
        .out_ready(out_ready), .interpolated_value(iv[2]), .out_sat(os[2]));
    lin_interp_pipe #(.DATA_W(8), .FRAC_W(4), .REM_W(6), .ROUND(0), .SAT(0)) u_xwrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .base(base),
        .next_data(next_data), .remaining(remaining), .out_valid(ov[3]),
        .out_ready(out_ready), .interpolated_value(iv[3]), .out_sat(os[3]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct { int b; int n; int r; } smp_t;
    smp_t q[$];

    task automatic ref_model(input int cfg, input smp_t s, output int val, output bit ovf);
        int rr, p, qv, sum, w;
        rr  = (cfg < 2) ? (s.r % 16) : s.r;
        p   = (s.n - s.b) * rr + ((cfg == 1) ? 8 : 0);
        qv  = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
        sum = s.b + qv;
        ovf = (sum > 127) || (sum < -128);
        if (cfg == 3) begin
            w   = ((sum % 256) + 256) % 256;
            val = (w > 127) ? w - 256 : w;
        end else begin
            val = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
        end
    endtask

    bit acc;
    int n_out;
    bit prev_ov, prev_rdy;
    int prev_iv[4];
    bit prev_os[4];

    task automatic step(input bit vin, input int b, input int n, input int r, input bit rdy);
        smp_t s;
        int   ev;
        bit   es;
        bit   exp_ir;
        @(negedge clk);
        in_valid  = vin;
        base      = 8'(b);
        next_data = 8'(n);
        remaining = 6'(r);
        out_ready = rdy;
        #1;
        exp_ir = (q.size() < 3) || rdy;
        for (int k = 1; k < 4; k++) check("valid_agree", ov[k], ov[0]);
        for (int k = 0; k < 4; k++) begin
            check("in_ready", ir[k], exp_ir);
            if (prev_ov && !prev_rdy) begin
                check("hold_valid", ov[k], 1);
                check("hold_value", iv[k], prev_iv[k]);
                check("hold_sat", os[k], prev_os[k]);
            end
            if (q.size() == 0) begin
                check("spurious_valid", ov[k], 0);
            end else if (ov[k]) begin
                ref_model(k, q[0], ev, es);
                check("value", iv[k], ev);
                check("sat_flag", os[k], es);
            end
        end
        prev_ov  = ov[0];
        prev_rdy = rdy;
        for (int k = 0; k < 4; k++) begin
            prev_iv[k] = iv[k];
            prev_os[k] = os[k];
        end
        if (ov[0] && rdy) begin
            void'(q.pop_front());
            n_out++;
        end
        acc = vin && ir[0];
        if (acc) begin
            s = '{b, n, r};
            q.push_back(s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_valid", ov[k], 0);
            check("rst_value", iv[k], 0);
            check("rst_sat", os[k], 0);
            check("rst_ready", ir[k], 1);
        end
        q.delete();
        prev_ov = 1'b0;
    endtask

    task automatic send_one(input int b, input int n, input int r);
        step(1'b1, b, n, r, 1'b1);
        check("accept", acc, 1);
        step(1'b0, 0, 0, 0, 1'b1);
        check("lat_c1", ov[0], 0);
        step(1'b0, 0, 0, 0, 1'b1);
        check("lat_c2", ov[0], 0);
        step(1'b0, 0, 0, 0, 1'b1);
        check("lat_c3", ov[0], 1);
    endtask

    initial begin
        int sent;
        bit rdy;
        do_reset();

        send_one(10, 30, 8);
        check("basic_value", iv[0], 20);
        check("basic_sat", os[0], 0);
        send_one(30, 10, 1);
        check("floor", iv[0], 28);
        check("round", iv[1], 29);
        send_one(100, 120, 48);
        check("ext_sat", iv[2], 127);
        check("ext_sat_flag", os[2], 1);
        check("ext_wrap", iv[3], -96);
        check("ext_wrap_flag", os[3], 1);
        send_one(-100, -120, 48);
        check("ext_neg", iv[2], -128);
        check("ext_neg_flag", os[2], 1);

        sent  = 0;
        n_out = 0;
        for (int c = 0; c < 40; c++) begin
            rdy = !(c >= 4 && c <= 8);
            step(sent < 10, 10 * sent - 50, 5 * sent, sent + 1, rdy);
            if (acc) sent++;
            if (c == 4) check("bp_full_ready", ir[0], 0);
        end
        check("bp_sent", sent, 10);
        check("bp_count", n_out, 10);

        sent  = 0;
        n_out = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            step(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 63)),
                 ($urandom % 5) < 3);
            if (acc) sent++;
        end
        check("rand_sent", sent, 1000);
        for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, 0, 0, 0, 1'b1);
        check("rand_drain", q.size(), 0);
        check("rand_count", n_out, 1000);

        for (int i = 0; i < 3; i++) step(1'b1, i, 100, 9, 1'b0);
        check("rst_inflight", q.size(), 3);
        do_reset();
        n_out = 0;
        for (int c = 0; c < 6; c++) step(1'b0, 0, 0, 0, 1'b1);
        check("rst_stale", n_out, 0);
        send_one(-50, 50, 15);
        check("post_rst", iv[0], 43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
